// File: rtl/move_scheduler_if.sv
// rtl/move_scheduler_if.sv - move command handshake between scheduler and movement datapath
interface move_scheduler_if;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_gravity;
  logic       cmd_ack;
  logic       cmd_blocked;

  modport master (
    output cmd_valid, cmd_dir, cmd_gravity,
    input  cmd_ack, cmd_blocked
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_gravity,
    output cmd_ack, cmd_blocked
  );
endinterface

// File: rtl/move_scheduler.sv
// rtl/move_scheduler.sv - serialises button, soft-drop and gravity requests into single-step move commands
module move_scheduler #(
  parameter int GRAVITY_FRAMES = 30,
  parameter int LEVEL_STEP     = 2,
  parameter int MIN_GRAVITY    = 4,
  parameter int REPEAT_FRAMES  = 8
) (
  input  logic                  vclk,
  input  logic                  rst,
  input  logic                  frame,
  input  logic                  enable,
  input  logic                  LEFT,
  input  logic                  RIGHT,
  input  logic                  DOWN,
  input  logic [3:0]            level,
  move_scheduler_if.master      cmd,
  output logic                  landed,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, LANDED} state_t;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [7:0] REP_LOAD  = 8'(REPEAT_FRAMES);

  state_t            state, state_n;
  logic              pend_l, pend_r, pend_d, pend_grav;
  logic              l_n, r_n, d_n, g_n;
  logic signed [8:0] period_raw;
  logic [7:0]        period;
  logic [7:0]        grav_elapsed;
  logic              grav_expire;
  logic [1:0]        btn, btn_q, arm, edge_now, lat_req;
  logic [7:0]        rep_cnt [2];
  logic              frame_ok, ack_fire;
  logic [1:0]        dir_n;
  logic              grav_n;

  assign btn      = {RIGHT, LEFT};
  // Frames only count in play and never while parked after a landing.
  assign frame_ok = frame & enable & (state != LANDED);
  assign ack_fire = cmd.cmd_valid & cmd.cmd_ack;

  // Gravity period: level-scaled, clamped so a negative result lands on the floor.
  always_comb begin
    period_raw = 9'(GRAVITY_FRAMES) - ({5'd0, level} * 9'(LEVEL_STEP));
    if (period_raw < $signed(9'(MIN_GRAVITY)))
      period = 8'(MIN_GRAVITY);
    else
      period = period_raw[7:0];
    grav_expire = frame_ok && (({1'b0, grav_elapsed} + 9'd1) >= {1'b0, period});
  end

  // Frames since the last gravity step; zero here is the "freshly reloaded" state.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst)
      grav_elapsed <= 8'd0;
    else if (!enable)
      grav_elapsed <= 8'd0;
    else if (frame_ok)
      grav_elapsed <= grav_expire ? 8'd0 : grav_elapsed + 8'd1;
  end

  // Lateral requests: a fresh press fires on the next frame, a held button on repeat expiry.
  always_comb begin
    edge_now = btn & ~btn_q;
    lat_req  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (frame_ok) begin
        if (arm[i] || edge_now[i])
          lat_req[i] = 1'b1;
        else if (btn[i] && rep_cnt[i] <= 8'd1)
          lat_req[i] = 1'b1;
      end
    end
  end

  // Press arming and per-button auto-repeat counters.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      btn_q      <= 2'b00;
      arm        <= 2'b00;
      rep_cnt[0] <= 8'd0;
      rep_cnt[1] <= 8'd0;
    end else begin
      btn_q <= btn;
      for (int i = 0; i < 2; i++) begin
        if (!enable) begin
          arm[i] <= 1'b0;
        end else if (frame_ok && (arm[i] || edge_now[i])) begin
          arm[i]     <= 1'b0;
          rep_cnt[i] <= REP_LOAD;
        end else begin
          if (edge_now[i])
            arm[i] <= 1'b1;
          if (frame_ok && btn[i])
            rep_cnt[i] <= (rep_cnt[i] <= 8'd1) ? REP_LOAD : rep_cnt[i] - 8'd1;
        end
      end
    end
  end

  // Next-state and command selection: lateral first, then one merged down step.
  always_comb begin
    state_n = state;
    dir_n   = cmd.cmd_dir;
    grav_n  = cmd.cmd_gravity;
    case (state)
      IDLE: begin
        if (enable && (pend_l || pend_r || pend_d || pend_grav)) begin
          state_n = ISSUE;
          if (pend_l) begin
            dir_n  = DIR_LEFT;
            grav_n = 1'b0;
          end else if (pend_r) begin
            dir_n  = DIR_RIGHT;
            grav_n = 1'b0;
          end else begin
            dir_n  = DIR_DOWN;
            grav_n = pend_grav;
          end
        end
      end
      ISSUE, WAIT_ACK: begin
        if (ack_fire)
          state_n = (cmd.cmd_dir == DIR_DOWN && cmd.cmd_blocked) ? LANDED : IDLE;
        else
          state_n = WAIT_ACK;
      end
      LANDED: begin
        if (!enable)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending flags: clear what was served, OR in new requests, cancel opposing laterals.
  always_comb begin
    l_n = pend_l;
    r_n = pend_r;
    d_n = pend_d;
    g_n = pend_grav;
    if (ack_fire) begin
      case (cmd.cmd_dir)
        DIR_LEFT:  l_n = 1'b0;
        DIR_RIGHT: r_n = 1'b0;
        default: begin
          d_n = 1'b0;
          if (cmd.cmd_gravity)
            g_n = 1'b0;
        end
      endcase
    end
    l_n = l_n | lat_req[0];
    r_n = r_n | lat_req[1];
    d_n = d_n | (frame_ok & DOWN);
    g_n = g_n | grav_expire;
    if (l_n && r_n) begin
      l_n = 1'b0;
      r_n = 1'b0;
    end
    if (!enable || state == LANDED || state_n == LANDED) begin
      l_n = 1'b0;
      r_n = 1'b0;
      d_n = 1'b0;
      g_n = 1'b0;
    end
  end

  // State, flags and registered outputs.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pend_l          <= 1'b0;
      pend_r          <= 1'b0;
      pend_d          <= 1'b0;
      pend_grav       <= 1'b0;
      cmd.cmd_valid   <= 1'b0;
      cmd.cmd_dir     <= DIR_LEFT;
      cmd.cmd_gravity <= 1'b0;
      landed          <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state         <= state_n;
      pend_l        <= l_n;
      pend_r        <= r_n;
      pend_d        <= d_n;
      pend_grav     <= g_n;
      cmd.cmd_valid <= (state_n == ISSUE) || (state_n == WAIT_ACK);
      if (state == IDLE && state_n == ISSUE) begin
        cmd.cmd_dir     <= dir_n;
        cmd.cmd_gravity <= grav_n;
      end
      landed <= (state_n == LANDED) && (state != LANDED);
      busy   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// tb/tb_move_scheduler.sv - self-checking bench for move_scheduler
module tb_move_scheduler;
  localparam int RF = 8;
  localparam int FG = 40;

  logic vclk = 1'b0, rst = 1'b1, frame = 1'b0, enable = 1'b0;
  logic LEFT = 1'b0, RIGHT = 1'b0, DOWN = 1'b0;
  logic [3:0] level = 4'd0;
  logic landed, busy;
  int cyc = 0;

  move_scheduler_if bus();

  move_scheduler dut (
    .vclk(vclk), .rst(rst), .frame(frame), .enable(enable),
    .LEFT(LEFT), .RIGHT(RIGHT), .DOWN(DOWN), .level(level),
    .cmd(bus), .landed(landed), .busy(busy)
  );

  always #5 vclk = ~vclk;
  always @(posedge vclk) cyc <= cyc + 1;

  int tests = 0, fails = 0;
  int fidx = 0, frame_cyc = 0;
  bit first_cmd = 0;
  logic [2:0] exp_q[$];
  int ack_lo = 0, ack_hi = 0;
  bit block_down = 0;
  int n_left = 0, n_right = 0, n_down = 0, n_grav = 0, n_landed = 0;
  int left_frames[$], grav_frames[$];

  // reference model state
  int gcount = 0;
  bit arm[2] = '{0, 0};
  int anchor[2] = '{0, 0};
  bit m_landed = 0, m_en = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int period_of(int lv);
    int p;
    p = 30 - lv * 2;
    return (p < 4) ? 4 : p;
  endfunction

  task automatic model_frame();
    bit g;
    bit r[2];
    bit held;
    if (!m_en || m_landed) return;
    gcount++;
    g = (gcount >= period_of(int'(level)));
    if (g) gcount = 0;
    for (int i = 0; i < 2; i++) begin
      held = (i == 0) ? LEFT : RIGHT;
      r[i] = 0;
      if (arm[i]) begin
        r[i] = 1; arm[i] = 0; anchor[i] = fidx;
      end else if (held && ((fidx - anchor[i]) % RF == 0)) begin
        r[i] = 1;
      end
    end
    if (r[0] ^ r[1]) exp_q.push_back({r[1] ? 2'b01 : 2'b00, 1'b0});
    if (DOWN || g) begin
      exp_q.push_back({2'b10, g});
      if (block_down) m_landed = 1;
    end
  endtask

  task automatic pulse_frame(int gap);
    check("drain_before_frame", exp_q.size(), 0);
    fidx++;
    model_frame();
    @(negedge vclk);
    frame = 1; frame_cyc = cyc; first_cmd = 1;
    @(negedge vclk);
    frame = 0;
    repeat (gap) @(negedge vclk);
  endtask

  task automatic set_btn(bit l, bit r, bit d);
    @(negedge vclk);
    if (m_en && l && !LEFT) arm[0] = 1;
    if (m_en && r && !RIGHT) arm[1] = 1;
    LEFT = l; RIGHT = r; DOWN = d;
  endtask

  task automatic set_en(bit e);
    @(negedge vclk);
    enable = e; m_en = e;
    if (!e) begin gcount = 0; arm = '{0, 0}; m_landed = 0; end
  endtask

  task automatic clr_counts();
    n_left = 0; n_right = 0; n_down = 0; n_grav = 0; n_landed = 0; fidx = 0;
    left_frames.delete(); grav_frames.delete();
  endtask

  task automatic wait_valid(int lim);
    int n = 0;
    while (!bus.cmd_valid && n < lim) begin @(negedge vclk); n++; end
    check("valid_seen", int'(bus.cmd_valid), 1);
  endtask

  // ack responder: random delay, occasional stray acks while idle
  initial begin
    int wl;
    wl = -1;
    bus.cmd_ack = 0; bus.cmd_blocked = 0;
    forever begin
      @(negedge vclk);
      bus.cmd_ack = 0; bus.cmd_blocked = 0;
      if (rst) begin wl = -1; continue; end
      if (bus.cmd_valid) begin
        if (wl < 0) wl = $urandom_range(ack_hi, ack_lo);
        if (wl == 0) begin
          bus.cmd_ack = 1;
          bus.cmd_blocked = (bus.cmd_dir == 2'b10) ? block_down : 1'($urandom % 2);
          wl = -1;
        end else wl--;
      end else if ($urandom % 4 == 0) begin
        bus.cmd_ack = 1; bus.cmd_blocked = 1'($urandom % 2);
      end
    end
  end

  // per-cycle compare against the model queue
  initial begin
    bit pv, pa, pg, exp_land;
    logic [1:0] pd;
    logic [2:0] e;
    pv = 0; pa = 0; pg = 0; pd = 0; exp_land = 0;
    forever begin
      @(negedge vclk); #1;
      if (rst) begin pv = 0; exp_land = 0; continue; end
      if (landed || exp_land) check("landed_pulse", int'(landed), int'(exp_land));
      if (landed) n_landed++;
      exp_land = 0;
      if (pv && !pa)
        check("cmd_hold", int'({bus.cmd_valid, bus.cmd_dir, bus.cmd_gravity}), int'({1'b1, pd, pg}));
      if (bus.cmd_valid) begin
        check("busy_with_valid", int'(busy), 1);
        if (!pv && first_cmd) begin
          check("frame_to_valid", cyc - frame_cyc, 2);
          first_cmd = 0;
        end
      end
      if (bus.cmd_valid && bus.cmd_ack) begin
        if (exp_q.size() == 0) check("unexpected_cmd", int'({bus.cmd_dir, bus.cmd_gravity}), -1);
        else begin
          e = exp_q.pop_front();
          check("cmd_dir_grav", int'({bus.cmd_dir, bus.cmd_gravity}), int'(e));
        end
        case (bus.cmd_dir)
          2'b00: begin n_left++; left_frames.push_back(fidx); end
          2'b01: n_right++;
          default: begin
            n_down++;
            if (bus.cmd_gravity) begin n_grav++; grav_frames.push_back(fidx); end
          end
        endcase
        if (bus.cmd_dir == 2'b10 && bus.cmd_blocked) exp_land = 1;
      end
      pv = bus.cmd_valid; pa = bus.cmd_ack; pd = bus.cmd_dir; pg = bus.cmd_gravity;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge vclk);
    check("reset_outputs", int'({bus.cmd_valid, bus.cmd_dir, bus.cmd_gravity, landed, busy}), 0);
    @(negedge vclk); rst = 0;
    repeat (3) @(negedge vclk);
    check("idle_busy", int'(busy), 0);

    // gravity at level 0
    set_en(1); clr_counts();
    repeat (60) pulse_frame(FG - 2);
    check("l0_grav_count", n_grav, 2);
    check("l0_down_count", n_down, 2);
    check("l0_grav_f0", grav_frames.size() > 0 ? grav_frames[0] : -1, 30);
    check("l0_grav_f1", grav_frames.size() > 1 ? grav_frames[1] : -1, 60);

    // clamped period at level 15
    set_en(0); level = 4'd15; set_en(1); clr_counts();
    repeat (20) pulse_frame(FG - 2);
    check("l15_grav_count", n_grav, 5);

    // held LEFT auto-repeat, then LEFT+RIGHT cancel
    set_en(0); level = 4'd0; set_en(1); clr_counts();
    set_btn(1, 0, 0);
    repeat (20) pulse_frame(FG - 2);
    set_btn(0, 0, 0);
    check("left_count", n_left, 3);
    check("left_f0", left_frames.size() > 0 ? left_frames[0] : -1, 1);
    check("left_f1", left_frames.size() > 1 ? left_frames[1] : -1, 9);
    check("left_f2", left_frames.size() > 2 ? left_frames[2] : -1, 17);
    set_btn(1, 1, 0);
    pulse_frame(FG - 2);
    set_btn(0, 0, 0);
    check("lr_cancel_left", n_left, 3);
    check("lr_cancel_right", n_right, 0);

    // soft drop merged with gravity
    set_en(0); level = 4'd15; set_en(1); clr_counts();
    repeat (3) pulse_frame(FG - 2);
    set_btn(0, 0, 1);
    pulse_frame(FG - 2);
    set_btn(0, 0, 0);
    check("merge_down_count", n_down, 1);
    check("merge_grav_count", n_grav, 1);

    // blocked down lands and parks the scheduler
    clr_counts(); block_down = 1;
    set_btn(0, 0, 1);
    pulse_frame(FG - 2);
    set_btn(0, 0, 0);
    repeat (10) pulse_frame(FG - 2);
    check("landed_count", n_landed, 1);
    check("landed_down_count", n_down, 1);
    check("landed_busy", int'(busy), 1);
    block_down = 0;
    set_en(0);
    repeat (3) @(negedge vclk);
    check("unland_busy", int'(busy), 0);
    set_en(1);
    set_btn(0, 0, 1);
    pulse_frame(FG - 2);
    set_btn(0, 0, 0);
    check("resume_down_count", n_down, 2);

    // enable drops mid-handshake with a slow ack
    clr_counts(); ack_lo = 5; ack_hi = 5;
    set_btn(0, 0, 1);
    pulse_frame(0);
    DOWN = 0;
    wait_valid(10);
    set_en(0);
    repeat (12) @(negedge vclk);
    check("endrop_valid", int'(bus.cmd_valid), 0);
    check("endrop_busy", int'(busy), 0);
    check("endrop_down", n_down, 1);
    ack_lo = 0; ack_hi = 0;
    set_en(1);
    repeat (3) pulse_frame(FG - 2);
    check("endrop_no_leftover", n_down, 1);

    // asynchronous reset mid-handshake
    ack_lo = 30; ack_hi = 30;
    set_btn(0, 0, 1);
    pulse_frame(1);
    set_btn(0, 0, 0);
    wait_valid(10);
    check("pre_rst_valid", int'({bus.cmd_valid, bus.cmd_dir}), 6);
    @(negedge vclk); #2;
    rst = 1;
    #1;
    check("async_rst_outputs", int'({bus.cmd_valid, bus.cmd_dir, bus.cmd_gravity, landed, busy}), 0);
    exp_q.delete();
    @(negedge vclk); @(negedge vclk);
    rst = 0; gcount = 0; arm = '{0, 0}; m_landed = 0;
    ack_lo = 0; ack_hi = 4;

    // randomized play
    clr_counts();
    for (int k = 0; k < 150; k++) begin
      if (k % 50 == 0) begin
        set_btn(0, 0, 0);
        set_en(0); level = 4'($urandom % 16); set_en(1);
      end
      set_btn(LEFT ^ ($urandom % 4 == 0), RIGHT ^ ($urandom % 4 == 0), DOWN ^ ($urandom % 3 == 0));
      pulse_frame(FG - 2);
    end
    set_btn(0, 0, 0);
    repeat (FG) @(negedge vclk);
    check("final_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
